mem_wb_writeback: RTL and testbench
===================================

// Module: mem_wb_writeback
// PURPOSE
//   MEM/WB pipeline register and writeback stage. Latches one instruction's WB control,
//   memory read data, ALU result and destination register at the MEM->WB boundary.
//   Drives the register-file write port (regwrite, write_reg, writedata) back into ID.
//   Keeps retire/load counters for debug and performance monitoring.
// PARAMETERS
//   DATA_W   32  datapath width (writedata, read_data, alu_result)
//   REG_AW   5   register address width (32 registers)
//   CNT_W    32  width of retire_count
//   LCNT_W   16  width of load_count
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   valid_in     in   1        MEM stage holds a real instruction (0 = bubble)
//   wb_ctrl      in   2        [1]=RegWrite, [0]=MemtoReg (RTYPE=2'b10, LW=2'b11, SW/BEQ=2'b00)
//   read_data    in   DATA_W   data-memory read result
//   alu_result   in   DATA_W   ALU result forwarded through MEM
//   dest_reg     in   REG_AW   destination register number
//   stall        in   1        hold the current WB entry; ignore MEM inputs
//   flush        in   1        replace the WB entry with a bubble
//   regwrite     out  1        register-file write enable
//   write_reg    out  REG_AW   register-file write address
//   writedata    out  DATA_W   register-file write data
//   retire_count out  CNT_W    number of valid instructions accepted into WB
//   load_count   out  LCNT_W   number of valid loads (MemtoReg=1) accepted into WB
// BEHAVIOUR
//   - Reset (async, rst=1): valid, ctrl, data, dest registers, both counters = 0.
//     Outputs regwrite=0, write_reg=0, writedata=0. Reset mid-operation drops the entry.
//   - Capture on posedge clk, priority flush > stall > load:
//       flush=1         : valid<=0; other fields don't-care (held)
//       stall=1         : all fields hold their values
//       otherwise       : valid<=valid_in, ctrl<=wb_ctrl, rd<=read_data, alu<=alu_result,
//                         dest<=dest_reg
//   - Latency: one cycle from the MEM inputs to the write-port outputs.
//   - writedata = ctrl[0] ? rd_q : alu_q (combinational from registered fields).
//   - write_reg = dest_q.
//   - regwrite = valid_q & ctrl[1] & (dest_q != 0). Writes to r0 are always suppressed.
//   - While stalled, regwrite stays asserted for a held valid entry. The repeated write
//     is idempotent and expected.
//   - Counters increment only on a load cycle (no flush, no stall) with valid_in=1:
//     retire_count+1; load_count+1 additionally if wb_ctrl[0]=1.
//     Both counters wrap modulo 2^width. A stalled entry is never recounted.
//   - Simultaneous flush+stall: flush wins; the bubble is inserted and counters don't move.
//   - Bubbles (valid_in=0) never assert regwrite, whatever the wb_ctrl value.
// CONFIGURATION
//   WB_BYPASS_EN defined: adds inputs id_rs, id_rt (REG_AW) and outputs
//     byp_a, byp_b (1) and byp_data (DATA_W).
//     byp_a = regwrite & (write_reg==id_rs); byp_b likewise for id_rt; byp_data = writedata.
//     All combinational, for same-cycle write-then-read forwarding into ID.
//   WB_BYPASS_EN undefined: those ports are absent; ID reads the register file only.
// TESTING
//   1. rst pulse mid-cycle with valid entry held -> all outputs 0 immediately, counters 0.
//   2. RTYPE: valid_in=1, wb_ctrl=10, alu=32'h1234, dest=5 -> next cycle regwrite=1,
//      write_reg=5, writedata=32'h1234; retire_count=1, load_count=0.
//   3. LW: wb_ctrl=11, read_data=32'hDEADBEEF, alu=32'h40, dest=8 -> writedata=32'hDEADBEEF,
//      regwrite=1; load_count increments by 1.
//   4. dest=0 with wb_ctrl=10, and SW wb_ctrl=00 -> regwrite=0 in both cases; retire_count still +1.
//   5. Stall 3 cycles on a held LW while changing MEM inputs -> outputs unchanged, counters +0;
//      then flush+stall together -> regwrite=0 next cycle.
//   6. Counter wrap: preload retire_count to all ones via repeated accepts -> next accept gives 0.
//      With WB_BYPASS_EN: id_rs=5 matches write_reg=5 and regwrite=1 -> byp_a=1,
//      byp_data=writedata.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file writeback port, with retire/load counters.
// Optional same-cycle WB->ID forwarding outputs are enabled by defining WB_BYPASS_EN.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  parameter int LCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              stall,
  input  logic              flush,
`ifdef WB_BYPASS_EN
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              byp_a,
  output logic              byp_b,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic              regwrite,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] writedata,
  output logic [CNT_W-1:0]  retire_count,
  output logic [LCNT_W-1:0] load_count
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        ctrl;   // [1]=RegWrite, [0]=MemtoReg
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] dest;
  } wb_entry_t;

  localparam logic [CNT_W-1:0]  RET_ONE = CNT_W'(1);
  localparam logic [LCNT_W-1:0] LD_ONE  = LCNT_W'(1);

  wb_entry_t q;
  logic      accept;

  assign accept = !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q            <= '0;
      retire_count <= '0;
      load_count   <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (accept) begin
      q.valid <= valid_in;
      q.ctrl  <= wb_ctrl;
      q.rd    <= read_data;
      q.alu   <= alu_result;
      q.dest  <= dest_reg;
      // Counting only on accept keeps a stalled entry from being recounted.
      if (valid_in) begin
        retire_count <= retire_count + RET_ONE;
        if (wb_ctrl[0]) load_count <= load_count + LD_ONE;
      end
    end
  end

  // r0 is hardwired zero, so writes to it are dropped here rather than in the regfile.
  assign regwrite  = q.valid & q.ctrl[1] & (q.dest != '0);
  assign write_reg = q.dest;
  assign writedata = q.ctrl[0] ? q.rd : q.alu;

`ifdef WB_BYPASS_EN
  assign byp_a    = regwrite & (write_reg == id_rs);
  assign byp_b    = regwrite & (write_reg == id_rt);
  assign byp_data = writedata;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback; small counter widths make wraparound reachable.
module tb_mem_wb_writeback;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int LCNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [1:0]        wb_ctrl;
  logic [DATA_W-1:0] read_data, alu_result;
  logic [REG_AW-1:0] dest_reg;
  logic              stall, flush;
  logic              regwrite;
  logic [REG_AW-1:0] write_reg;
  logic [DATA_W-1:0] writedata;
  logic [CNT_W-1:0]  retire_count;
  logic [LCNT_W-1:0] load_count;
`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] id_rs, id_rt;
  logic              byp_a, byp_b;
  logic [DATA_W-1:0] byp_data;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W), .LCNT_W(LCNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .wb_ctrl(wb_ctrl),
    .read_data(read_data), .alu_result(alu_result), .dest_reg(dest_reg),
    .stall(stall), .flush(flush),
`ifdef WB_BYPASS_EN
    .id_rs(id_rs), .id_rt(id_rt), .byp_a(byp_a), .byp_b(byp_b), .byp_data(byp_data),
`endif
    .regwrite(regwrite), .write_reg(write_reg), .writedata(writedata),
    .retire_count(retire_count), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [DATA_W-1:0] rd,
                       input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] d,
                       input logic stl, input logic fl);
    valid_in = v; wb_ctrl = c; read_data = rd; alu_result = alu; dest_reg = d;
    stall = stl; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic rw, input logic [REG_AW-1:0] wr,
                          input logic [DATA_W-1:0] wd);
    chk({tag, ".regwrite"}, 64'(regwrite), 64'(rw));
    chk({tag, ".write_reg"}, 64'(write_reg), 64'(wr));
    chk({tag, ".writedata"}, 64'(writedata), 64'(wd));
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] r, input logic [LCNT_W-1:0] l);
    chk({tag, ".retire"}, 64'(retire_count), 64'(r));
    chk({tag, ".load"}, 64'(load_count), 64'(l));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, '0, '0, '0, 0, 0);
`ifdef WB_BYPASS_EN
    id_rs = '0; id_rt = '0;
`endif
    tick; tick;
    chk_port("reset", 0, 0, 0);
    chk_cnt("reset", 0, 0);
    @(negedge clk); rst = 1'b0;

    drive(1, 2'b10, 32'h0, 32'h1234, 5, 0, 0); tick;
    chk_port("rtype", 1, 5, 32'h1234);
    chk_cnt("rtype", 1, 0);

    drive(1, 2'b11, 32'hDEADBEEF, 32'h40, 8, 0, 0); tick;
    chk_port("lw", 1, 8, 32'hDEADBEEF);
    chk_cnt("lw", 2, 1);

    drive(1, 2'b10, 32'h0, 32'h77, 0, 0, 0); tick;
    chk_port("r0", 0, 0, 32'h77);
    chk_cnt("r0", 3, 1);

    drive(1, 2'b00, 32'h0, 32'h99, 3, 0, 0); tick;
    chk_port("sw", 0, 3, 32'h99);
    chk_cnt("sw", 4, 1);

    drive(0, 2'b11, 32'h5555, 32'h6666, 7, 0, 0); tick;
    chk("bubble.regwrite", 64'(regwrite), 64'd0);
    chk_cnt("bubble", 4, 1);

    drive(1, 2'b11, 32'hCAFEF00D, 32'h4, 9, 0, 0); tick;
    chk_port("lw2", 1, 9, 32'hCAFEF00D);
    chk_cnt("lw2", 5, 2);

    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 32'h100 + i, 32'h200 + i, 12, 1, 0); tick;
      chk_port($sformatf("stall%0d", i), 1, 9, 32'hCAFEF00D);
      chk_cnt($sformatf("stall%0d", i), 5, 2);
    end

    drive(1, 2'b10, 32'h0, 32'h300, 12, 1, 1); tick;
    chk("flushstall.regwrite", 64'(regwrite), 64'd0);
    chk_cnt("flushstall", 5, 2);

    drive(1, 2'b11, 32'h1, 32'h2, 4, 0, 1); tick;
    chk("flush.regwrite", 64'(regwrite), 64'd0);
    chk_cnt("flush", 5, 2);

    // Asynchronous reset between clock edges drops a live entry at once.
    drive(1, 2'b10, 32'h0, 32'h55, 6, 0, 0); tick;
    chk_port("prerst", 1, 6, 32'h55);
    chk_cnt("prerst", 6, 2);
    drive(0, 2'b00, '0, '0, '0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk_port("midrst", 0, 0, 0);
    chk_cnt("midrst", 0, 0);
    #2 rst = 1'b0;

    // Loads bump both counters: load_count (3b) wraps at 8, retire_count (4b) at 16.
    for (int n = 1; n <= 16; n++) begin
      drive(1, 2'b11, 32'h1000 + n, 32'h0, 1, 0, 0); tick;
      if (n == 7)  chk_cnt("wrap7", 7, 7);
      if (n == 8)  chk_cnt("wrap8", 8, 0);
      if (n == 15) chk_cnt("wrap15", 15, 7);
      if (n == 16) chk_cnt("wrap16", 0, 0);
    end

`ifdef WB_BYPASS_EN
    drive(1, 2'b10, 32'h0, 32'hABC, 5, 0, 0); tick;
    id_rs = 5; id_rt = 6; #1;
    chk("byp.a", 64'(byp_a), 64'd1);
    chk("byp.b", 64'(byp_b), 64'd0);
    chk("byp.data", 64'(byp_data), 64'hABC);
    drive(1, 2'b10, 32'h0, 32'hDEF, 0, 0, 0); tick;
    id_rs = 0; id_rt = 0; #1;
    chk("byp_r0.a", 64'(byp_a), 64'd0);
    chk("byp_r0.b", 64'(byp_b), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
